// File: rtl/fetch_pc_sequencer.sv
// Front-end PC sequencer: issues word-aligned fetches over req/ack, hands instructions
// to decode over valid/ready, and applies branch/jump/jump-register redirects from execute.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redir_valid,
    input  logic        redir_taken,
    input  logic [1:0]  redir_type,
    input  logic [31:0] redir_pc,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_reg,
    output logic        misalign_err
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [1:0] T_BRANCH = 2'b00;
    localparam logic [1:0] T_JUMP   = 2'b01;
    localparam logic [1:0] T_JREG   = 2'b10;

    state_t      state, next_state;
    logic [31:0] pc, next_pc;
    logic        squash, next_squash;
    logic        next_req;
    logic [31:0] next_addr;
    logic        next_valid;
    logic [31:0] next_instr, next_instr_pc;
    logic        next_misalign;

    logic        taken;
    logic [31:0] link_pc;
    logic [31:0] target;
    logic [31:0] refetch_pc;

    assign taken   = redir_valid && redir_taken && (redir_type != 2'b11);
    assign link_pc = redir_pc + 32'd4;

    // Redirect target; offsets and indices are in words, hence the shift by 2
    always_comb begin
        target = link_pc + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
        case (redir_type)
            T_BRANCH: target = link_pc + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
            T_JUMP:   target = {link_pc[31:28], redir_imm[25:0], 2'b00};
            T_JREG:   target = {redir_reg[31:2], 2'b00};
            default:  target = pc;
        endcase
    end

    assign refetch_pc = taken ? target : pc;

    always_comb begin
        next_state    = state;
        next_pc       = pc;
        next_squash   = squash;
        next_req      = imem_req;
        next_addr     = imem_addr;
        next_valid    = instr_valid;
        next_instr    = instr;
        next_instr_pc = instr_pc;
        next_misalign = taken && (redir_type == T_JREG) && (redir_reg[1:0] != 2'b00);

        case (state)
            S_REQ: begin
                if (!imem_req) begin
                    next_req  = 1'b1;
                    next_pc   = refetch_pc;
                    next_addr = refetch_pc;
                end else if (imem_ack) begin
                    if (squash || taken) begin
                        // Returned word belongs to a stale path: drop it and refetch
                        next_squash = 1'b0;
                        next_pc     = refetch_pc;
                        next_addr   = refetch_pc;
                        next_req    = 1'b1;
                    end else begin
                        next_instr    = imem_rdata;
                        next_instr_pc = imem_addr;
                        next_valid    = 1'b1;
                        next_pc       = imem_addr + 32'd4;
                        next_req      = 1'b0;
                        next_state    = S_HOLD;
                    end
                end else if (taken) begin
                    // Address must stay stable until ack, so remember to discard it
                    next_pc     = target;
                    next_squash = 1'b1;
                end
            end
            S_HOLD: begin
                if (taken) begin
                    next_valid = 1'b0;
                    next_pc    = target;
                    next_addr  = target;
                    next_req   = 1'b1;
                    next_state = S_REQ;
                end else if (instr_ready) begin
                    next_valid = 1'b0;
                    next_addr  = pc;
                    next_req   = 1'b1;
                    next_state = S_REQ;
                end
            end
            default: next_state = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            squash       <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            instr_valid  <= 1'b0;
            instr        <= 32'd0;
            instr_pc     <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            state        <= next_state;
            pc           <= next_pc;
            squash       <= next_squash;
            imem_req     <= next_req;
            imem_addr    <= next_addr;
            instr_valid  <= next_valid;
            instr        <= next_instr;
            instr_pc     <= next_instr_pc;
            misalign_err <= next_misalign;
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed self-checking bench for fetch_pc_sequencer with hand-computed expectations.
module tb_fetch_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redir_valid;
    logic        redir_taken;
    logic [1:0]  redir_type;
    logic [31:0] redir_pc;
    logic [25:0] redir_imm;
    logic [31:0] redir_reg;
    logic        misalign_err;

    int testsRun  = 0;
    int testsFail = 0;

    fetch_pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .redir_valid  (redir_valid),
        .redir_taken  (redir_taken),
        .redir_type   (redir_type),
        .redir_pc     (redir_pc),
        .redir_imm    (redir_imm),
        .redir_reg    (redir_reg),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic t, input logic [1:0] ty,
                                 input logic [31:0] rpc, input logic [25:0] imm, input logic [31:0] rreg);
        redir_valid = v;
        redir_taken = t;
        redir_type  = ty;
        redir_pc    = rpc;
        redir_imm   = imm;
        redir_reg   = rreg;
    endtask

    task automatic clearRedir();
        applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req"},   {31'd0, imem_req},     32'd0);
        checkOutput({tag, "_addr"},  imem_addr,             32'd0);
        checkOutput({tag, "_valid"}, {31'd0, instr_valid},  32'd0);
        checkOutput({tag, "_instr"}, instr,                 32'd0);
        checkOutput({tag, "_ipc"},   instr_pc,              32'd0);
        checkOutput({tag, "_mis"},   {31'd0, misalign_err}, 32'd0);
    endtask

    // One complete fetch with decode ready: request seen, ack, instruction held one cycle
    task automatic fetchOne(input string tag, input logic [31:0] expAddr, input logic [31:0] data);
        checkOutput({tag, "_req"},  {31'd0, imem_req}, 32'd1);
        checkOutput({tag, "_addr"}, imem_addr, expAddr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
        checkOutput({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        checkOutput({tag, "_instr"}, instr, data);
        checkOutput({tag, "_ipc"},   instr_pc, expAddr);
        checkOutput({tag, "_reqlo"}, {31'd0, imem_req}, 32'd0);
        tick();
        checkOutput({tag, "_vdrop"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b1;
        clearRedir();

        repeat (2) tick();
        checkReset("rst");
        rst_n = 1'b1;
        tick();

        // Sequential fetches 0x0, 0x4, 0x8
        fetchOne("seq0", 32'h0000_0000, 32'hAAAA_0000);
        fetchOne("seq1", 32'h0000_0004, 32'hAAAA_0004);
        fetchOne("seq2", 32'h0000_0008, 32'hAAAA_0008);

        // Decode stalls 5 cycles; not-taken and reserved-type redirects must be ignored
        checkOutput("stall_addr", imem_addr, 32'h0000_000C);
        imem_ack    = 1'b1;
        imem_rdata  = 32'h5555_000C;
        instr_ready = 1'b0;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) applyStimulus(1'b1, 1'b0, 2'b00, 32'h100, 26'h0FFFE, 32'd0);
            else if (i == 3) applyStimulus(1'b1, 1'b1, 2'b11, 32'h100, 26'h00040, 32'h3000);
            else clearRedir();
            checkOutput($sformatf("stall%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            checkOutput($sformatf("stall%0d_instr", i), instr, 32'h5555_000C);
            checkOutput($sformatf("stall%0d_ipc", i),   instr_pc, 32'h0000_000C);
            checkOutput($sformatf("stall%0d_req", i),   {31'd0, imem_req}, 32'd0);
            tick();
        end
        clearRedir();
        checkOutput("stall_hold_end", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        tick();
        checkOutput("stall_rel_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("stall_rel_addr",  imem_addr, 32'h0000_0010);

        // Taken branch in hold flushes even though decode is ready: 0x104 - 8 = 0xFC
        checkOutput("br_req", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_0010;
        tick();
        imem_ack = 1'b0;
        checkOutput("br_hold_valid", {31'd0, instr_valid}, 32'd1);
        applyStimulus(1'b1, 1'b1, 2'b00, 32'h0000_0100, 26'h000FFFE, 32'd0);
        tick();
        clearRedir();
        checkOutput("br_flush_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("br_flush_req",   {31'd0, imem_req}, 32'd1);
        checkOutput("br_flush_addr",  imem_addr, 32'h0000_00FC);

        // Jump while ack is held off 3 cycles: address stays until ack, data then discarded
        tick();
        applyStimulus(1'b1, 1'b1, 2'b01, 32'hF000_0010, 26'h0000040, 32'd0);
        tick();
        clearRedir();
        checkOutput("jmp_wait_addr1", imem_addr, 32'h0000_00FC);
        checkOutput("jmp_wait_req",   {31'd0, imem_req}, 32'd1);
        tick();
        checkOutput("jmp_wait_addr2", imem_addr, 32'h0000_00FC);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checkOutput("jmp_squash_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("jmp_squash_req",   {31'd0, imem_req}, 32'd1);
        checkOutput("jmp_target_addr",  imem_addr, 32'hF000_0100);
        fetchOne("jmp_fetch", 32'hF000_0100, 32'h2222_0100);

        // Misaligned jump-register coinciding with ack
        checkOutput("jr_pre_addr", imem_addr, 32'hF000_0104);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        applyStimulus(1'b1, 1'b1, 2'b10, 32'h0000_0000, 26'd0, 32'h0000_2006);
        tick();
        imem_ack = 1'b0;
        clearRedir();
        checkOutput("jr_drop_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("jr_mis_pulse",  {31'd0, misalign_err}, 32'd1);
        checkOutput("jr_addr",       imem_addr, 32'h0000_2004);
        checkOutput("jr_req",        {31'd0, imem_req}, 32'd1);
        tick();
        checkOutput("jr_mis_clear",  {31'd0, misalign_err}, 32'd0);
        fetchOne("jr_fetch", 32'h0000_2004, 32'h3333_2004);

        // Reset while a squashed request is outstanding; late ack during reset ignored
        applyStimulus(1'b1, 1'b1, 2'b00, 32'h0000_0200, 26'h0000010, 32'd0);
        tick();
        clearRedir();
        checkOutput("rs_pre_addr", imem_addr, 32'h0000_2008);
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h7777_7777;
        #1;
        checkReset("rs_async");
        tick();
        checkReset("rs_held");
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        tick();
        checkOutput("rs_rel_valid", {31'd0, instr_valid}, 32'd0);
        fetchOne("rs_fetch", 32'h0000_0000, 32'h4444_0000);
        checkOutput("rs_next_addr", imem_addr, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 100000ns");
        $fatal(1, "[TB] timeout");
    end

endmodule
